ro_scan_sequencer: RTL

RO_SCAN_SEQUENCER -- requirements
Module: ro_scan_sequencer

---
 rtl/ro_scan_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ro_scan_sequencer.sv
// Ring-oscillator scan sequencer: steps through the masked oscillators,
// settling, gating and capturing an external edge count for each one.
module ro_scan_sequencer #(
    parameter int unsigned GATE_CYCLES   = 10000,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [3:0]       osc_mask,
    output logic [3:0]       osc_en,
    output logic [1:0]       osc_sel,
    output logic             cnt_clr,
    output logic             cnt_en,
    input  logic [CNT_W-1:0] cnt_val,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_data,
    output logic [1:0]       res_id,
    output logic             res_ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned      TMR_W       = 16;
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_GATE,
        S_LATCH,
        S_OUT
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       cur_q, cur_d;
    logic [3:0]       mask_q, mask_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [1:0]       first_idx;
    logic [1:0]       next_idx;
    logic             next_found;
    logic             finish;

    // Lowest set bit of the incoming request mask.
    always_comb begin
        first_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (osc_mask[i]) first_idx = 2'(i);
        end
    end

    // Lowest set bit of the captured mask strictly above the current oscillator.
    always_comb begin
        next_idx   = cur_q;
        next_found = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(cur_q))) begin
                next_idx   = 2'(i);
                next_found = 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d = state_q;
        cur_d   = cur_q;
        mask_d  = mask_q;
        timer_d = timer_q;
        finish  = 1'b0;
        if (state_q != S_IDLE && !ena) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && ena && (osc_mask != 4'b0000)) begin
                        state_d = S_SETTLE;
                        mask_d  = osc_mask;
                        cur_d   = first_idx;
                        timer_d = SETTLE_LOAD;
                    end
                end
                S_SETTLE: begin
                    if (timer_q == '0) begin
                        state_d = S_GATE;
                        timer_d = GATE_LOAD;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                S_GATE: begin
                    if (timer_q == '0) state_d = S_LATCH;
                    else               timer_d = timer_q - 1'b1;
                end
                S_LATCH: state_d = S_OUT;
                S_OUT: begin
                    if (res_ready) begin
                        if (next_found) begin
                            state_d = S_SETTLE;
                            cur_d   = next_idx;
                            timer_d = SETTLE_LOAD;
                        end else begin
                            state_d = S_IDLE;
                            finish  = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cur_q     <= 2'd0;
            mask_q    <= 4'b0000;
            timer_q   <= '0;
            osc_en    <= 4'b0000;
            osc_sel   <= 2'd0;
            cnt_clr   <= 1'b0;
            cnt_en    <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= 2'd0;
            res_ovf   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q   <= state_d;
            cur_q     <= cur_d;
            mask_q    <= mask_d;
            timer_q   <= timer_d;
            osc_sel   <= cur_d;
            osc_en    <= 4'b0000;
            cnt_clr   <= 1'b0;
            cnt_en    <= 1'b0;
            res_valid <= 1'b0;
            case (state_d)
                S_SETTLE: begin
                    osc_en  <= 4'b0001 << cur_d;
                    cnt_clr <= 1'b1;
                end
                S_GATE: begin
                    osc_en <= 4'b0001 << cur_d;
                    cnt_en <= 1'b1;
                end
                S_LATCH: osc_en    <= 4'b0001 << cur_d;
                S_OUT:   res_valid <= 1'b1;
                default: ;
            endcase
            busy <= (state_d != S_IDLE);
            done <= finish;
            if (state_q == S_LATCH && ena) begin
                res_data <= cnt_val;
                res_id   <= cur_q;
                res_ovf  <= &cnt_val;
            end
        end
    end

endmodule
